// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared FSM state type, reset column pattern and scan helpers
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Lowest bit position holding a 0; serves both row selection and column index.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - two-stage synchronizer for the asynchronous keypad rows
module sync_2ff (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Clears to all-ones so a reset looks like "no key" downstream.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and valid/ready key output
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 20
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_TICKS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic [3:0]       rs;
  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             overrun_q, overrun_d;
  logic             tick, row_hi, confirm, accept;

  sync_2ff u_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (row_in),
    .q     (rs)
  );

  assign tick   = (div_q == DIV_LAST);
  assign row_hi = rs[row_idx_q];
  assign accept = key_valid_q && key_ready;

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    deb_d     = deb_q;
    confirm   = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rs != 4'hF) begin
            row_idx_d = low_index(rs);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = rotate_col(col_q);
          end
        end
        DEBOUNCE: begin
          if (row_hi) begin
            col_d   = rotate_col(col_q);
            state_d = SCAN;
          end else if (deb_q == DEB_LAST) begin
            confirm = 1'b1;
            state_d = HELD;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        HELD: begin
          if (row_hi) begin
            deb_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (!row_hi) begin
            state_d = HELD;
          end else if (deb_q == DEB_LAST) begin
            col_d   = rotate_col(col_q);
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    // A confirm in the accept cycle reloads the slot instead of letting valid drop.
    key_valid_d = key_valid_q && !accept;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    if (confirm) begin
      if (!key_valid_q || accept) begin
        key_code_d  = {row_idx_q, low_index(col_q)};
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    key_down_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      div_q       <= '0;
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      row_idx_q   <= '0;
      deb_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_out   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a switch-matrix keypad model
module tb_keypad_scanner;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       overrun;

  logic [15:0] pressed = '0;  // bit r*4+c closes the switch between row r and column c
  logic [3:0]  got_codes[$];
  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Every beat that will be accepted at the next rising edge.
  always @(negedge CLK)
    if (!Reset && key_valid && key_ready) got_codes.push_back(key_code);

  task automatic do_reset();
    @(posedge CLK); #1 Reset = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK); Reset = 1'b0;
  endtask

  task automatic wait_col(input logic [3:0] target, output bit ok);
    int t;
    t = 0;
    while (col_out === target && t < 40) begin @(negedge CLK); t++; end
    while (col_out !== target && t < 40) begin @(negedge CLK); t++; end
    ok = (col_out === target);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    pressed = '0; key_ready = 1'b0;
    @(posedge CLK); #1 Reset = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", col_out); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    vectors++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down got=%b exp=0", key_down); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    Reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      exp_col = 4'hF ^ (4'b0001 << (((k + 1) / 4) % 4));
      vectors++;
      if (col_out !== exp_col) begin errors++; $display("FAIL rotate_c%0d got=%b exp=%b", k, col_out, exp_col); end
    end
  endtask

  task automatic test_press();
    int t;
    int fall;
    got_codes.delete(); key_ready = 1'b1;
    pressed[2*4+1] = 1'b1;
    t = 0;
    while (key_valid !== 1'b1 && t < 200) begin @(negedge CLK); t++; end
    vectors++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_timeout got=%b exp=1", key_valid); end
    vectors++; if (key_code !== 4'h9) begin errors++; $display("FAIL press_code got=%h exp=9", key_code); end
    repeat (40) @(negedge CLK);
    vectors++; if (key_down !== 1'b1) begin errors++; $display("FAIL press_down_held got=%b exp=1", key_down); end
    pressed = '0;
    fall = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (key_down !== 1'b1 && fall < 0) fall = i;
    end
    vectors++;
    if (fall < 12 || fall > 20) begin errors++; $display("FAIL press_release_delay got=%0d exp=12..20", fall); end
    vectors++;
    if (got_codes.size() != 1) begin errors++; $display("FAIL press_beats got=%0d exp=1", got_codes.size()); end
    else if (got_codes[0] !== 4'h9) begin errors++; $display("FAIL press_beat_code got=%h exp=9", got_codes[0]); end
  endtask

  task automatic test_bounce();
    bit ok;
    bit saw_valid;
    logic [3:0] next_col;
    got_codes.delete(); key_ready = 1'b1;
    wait_col(4'b0111, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL bounce_col_wait got=%b exp=0111", col_out); end
    pressed[1*4+3] = 1'b1;
    repeat (4) @(negedge CLK);
    vectors++; if (col_out !== 4'b0111) begin errors++; $display("FAIL bounce_frozen got=%b exp=0111", col_out); end
    pressed = '0;
    saw_valid = 1'b0; next_col = 4'hF;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (key_valid === 1'b1 || key_down === 1'b1) saw_valid = 1'b1;
      if (next_col === 4'hF && col_out !== 4'b0111) next_col = col_out;
    end
    vectors++; if (saw_valid) begin errors++; $display("FAIL bounce_no_key got=1 exp=0"); end
    vectors++; if (next_col !== 4'b1110) begin errors++; $display("FAIL bounce_resume got=%b exp=1110", next_col); end
  endtask

  task automatic test_overrun();
    do_reset();
    got_codes.delete(); key_ready = 1'b0;
    pressed[1*4+1] = 1'b1; repeat (60) @(negedge CLK);
    pressed = '0;          repeat (40) @(negedge CLK);
    pressed[2*4+2] = 1'b1; repeat (60) @(negedge CLK);
    pressed = '0;          repeat (40) @(negedge CLK);
    vectors++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", key_valid); end
    vectors++; if (key_code !== 4'h5) begin errors++; $display("FAIL ovr_code got=%h exp=5", key_code); end
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    key_ready = 1'b1;
    @(negedge CLK);
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop got=%b exp=0", key_valid); end
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    vectors++;
    if (got_codes.size() != 1) begin errors++; $display("FAIL ovr_beats got=%0d exp=1", got_codes.size()); end
    else if (got_codes[0] !== 4'h5) begin errors++; $display("FAIL ovr_beat_code got=%h exp=5", got_codes[0]); end
  endtask

  task automatic test_back_to_back();
    int t;
    bit ok;
    do_reset();
    got_codes.delete(); key_ready = 1'b0;
    pressed[1*4+0] = 1'b1; pressed[3*4+0] = 1'b1;
    t = 0;
    while (key_valid !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
    vectors++; if (key_code !== 4'h4 || key_valid !== 1'b1) begin errors++; $display("FAIL multi_row got=%h/%b exp=4/1", key_code, key_valid); end
    pressed = '0;
    repeat (40) @(negedge CLK);
    wait_col(4'b1011, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL b2b_col_wait got=%b exp=1011", col_out); end
    // Column just rotated on a tick edge: first tick seeing the key is 4 edges on, confirm 3 ticks later.
    pressed[2*4+2] = 1'b1;
    repeat (15) @(posedge CLK);
    #1 key_ready = 1'b1;
    @(posedge CLK);
    #1 key_ready = 1'b0;
    @(negedge CLK);
    vectors++; if (key_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", key_valid); end
    vectors++; if (key_code !== 4'hA) begin errors++; $display("FAIL b2b_code got=%h exp=a", key_code); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    vectors++; if (key_down !== 1'b1) begin errors++; $display("FAIL b2b_down got=%b exp=1", key_down); end
    vectors++;
    if (got_codes.size() != 1) begin errors++; $display("FAIL b2b_beats got=%0d exp=1", got_codes.size()); end
    else if (got_codes[0] !== 4'h4) begin errors++; $display("FAIL b2b_beat_code got=%h exp=4", got_codes[0]); end
    key_ready = 1'b1; pressed = '0;
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw_valid;
    logic [3:0] next_col;
    got_codes.delete(); key_ready = 1'b1;
    wait_col(4'b0111, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL rmid_col_wait got=%b exp=0111", col_out); end
    pressed[3*4+3] = 1'b1;
    repeat (6) @(negedge CLK);
    Reset = 1'b1; pressed = '0;
    repeat (2) @(negedge CLK);
    vectors++; if (col_out !== 4'b1110) begin errors++; $display("FAIL rmid_col got=%b exp=1110", col_out); end
    vectors++; if (key_valid !== 1'b0 || key_down !== 1'b0) begin errors++; $display("FAIL rmid_flags got=%b%b exp=00", key_valid, key_down); end
    Reset = 1'b0;
    saw_valid = 1'b0; next_col = 4'hF;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (key_valid === 1'b1) saw_valid = 1'b1;
      if (next_col === 4'hF && col_out !== 4'b1110) next_col = col_out;
    end
    vectors++; if (saw_valid || got_codes.size() != 0) begin errors++; $display("FAIL rmid_no_valid got=%0d beats exp=0", got_codes.size()); end
    vectors++; if (next_col !== 4'b1101) begin errors++; $display("FAIL rmid_scan got=%b exp=1101", next_col); end
  endtask

  task automatic test_random();
    logic [3:0] exp_codes[$];
    int key;
    int dur;
    bit long_press;
    do_reset();
    got_codes.delete(); key_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      key = $urandom_range(0, 15);
      long_press = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dur = long_press ? $urandom_range(40, 70) : $urandom_range(1, 7);
      pressed = 16'd1 << key;
      repeat (dur) @(negedge CLK);
      pressed = '0;
      repeat (40) @(negedge CLK);
      // A long press must surface as {row, col}; a glitch shorter than the debounce window never does.
      if (long_press) exp_codes.push_back(4'((key / 4) * 4 + (key % 4)));
    end
    vectors++;
    if (got_codes.size() != exp_codes.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got_codes.size(), exp_codes.size());
    end
    for (int i = 0; i < exp_codes.size() && i < got_codes.size(); i++) begin
      vectors++;
      if (got_codes[i] !== exp_codes[i]) begin errors++; $display("FAIL rand_code%0d got=%h exp=%h", i, got_codes[i], exp_codes[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
